comp_arbiter: RTL and testbench
===============================

// Module: comp_arbiter
// PURPOSE
//  Shares the single Execute-stage comparator (comp) between two requesters: the branch unit (BR)
//  and the set-less-than path (SLT/SLTU). Arbitrates with BR priority, bounded SLT starvation,
//  registers the 1-bit result with a valid/ready output slot, and supports pipeline flush of BR work.
//  Sits between Decode/Execute operand select and the PC-redirect / writeback consumers.
// PARAMETERS
//  XLEN        32  operand width; matches core_general.vh
//  STARVE_MAX  3   max consecutive BR grants while SLT is waiting before SLT is forced (1..15)
// PORTS
//  clk          in   1     core clock
//  rst_n        in   1     asynchronous active-low reset
//  br_valid     in   1     BR request valid
//  br_ready     out  1     BR request accepted this cycle
//  br_rs1       in   XLEN  BR operand 1
//  br_rs2       in   XLEN  BR operand 2
//  br_funct3    in   3     BEQ/BNE/BLT/BGE/BLTU/BGEU encoding
//  slt_valid    in   1     SLT request valid
//  slt_ready    out  1     SLT request accepted this cycle
//  slt_rs1      in   XLEN  SLT operand 1
//  slt_rs2      in   XLEN  SLT operand 2
//  slt_unsigned in   1     0=SLT (signed), 1=SLTU
//  flush        in   1     discard all BR work (accepted or held); SLT unaffected
//  res_valid    out  1     result slot occupied
//  res_ready    in   1     consumer takes result when res_valid&res_ready
//  res_src      out  1     0=BR, 1=SLT
//  res_value    out  1     comparison outcome (taken / set)
//  res_illegal  out  1     BR request carried funct3 010/011; res_value forced 0
// BEHAVIOUR
//  Reset: res_valid=0, res_src=0, res_value=0, res_illegal=0, starve_cnt=0, state=EMPTY.
//  Acceptance: a request is accepted on a cycle where valid&ready; ready=can_load & grant.
//   can_load = (state==EMPTY) | (res_valid & res_ready).  No combinational path valid->own ready
//   except through grant; ready never depends on res_value.
//  Grant: BR wins if br_valid & !(slt_valid & starve_cnt==STARVE_MAX); else SLT if slt_valid.
//   flush=1 forces br_ready=0 that cycle (SLT may still be granted).
//  starve_cnt: +1 on BR accept while slt_valid; clears on SLT accept or when slt_valid=0; saturates.
//  Operand mapping into comp: BR funct3 passed unchanged; SLT -> BLT (100), SLTU -> BLTU (110).
//   decoded_op built OPLEN-wide, only FUNCT3 field populated, rest 0.
//  Latency: accept in cycle N -> res_valid, res_value, res_src valid from cycle N+1 (registered).
//  FSM: EMPTY --accept--> FULL; FULL --drain & !accept--> EMPTY; FULL --drain & accept--> FULL
//   (back-to-back, 1 result/cycle throughput); FULL & !res_ready -> FULL, outputs held stable.
//  Flush: if state==FULL & res_src==0, slot cleared next cycle (res_valid=0) unless same-cycle drain;
//   flush coinciding with drain: drain counts, slot then follows normal rules. SLT slot kept.
//  Illegal BR funct3 (010, 011): accepted, res_value=0, res_illegal=1; comp's X never propagates.
//  Reset mid-operation: slot and counter cleared immediately; in-flight request lost (requester retries).
// STRUCTURE
//  Shared package/header core_general.vh: FUNCT3_* codes, FUNCT3_BIT_M/L, XLEN, OPLEN; add
//   RES_SRC_BR/RES_SRC_SLT constants there. One sub-module: comp (instance u_comp), combinational.
//  Local: grant logic, starve counter, 2-state slot FSM, result register.
// TESTING
//  BR BLT rs1=-1 rs2=1 alone, res_ready=1 -> br_ready=1, next cycle res_valid=1 src=0 value=1.
//  SLTU rs1=0xFFFFFFFF rs2=1 -> res_src=1 value=0; same operands SLT -> value=1.
//  BR and SLT valid every cycle, res_ready=1, STARVE_MAX=3 -> grants BR,BR,BR,SLT repeating.
//  res_ready=0 for 5 cycles after BEQ 5==5 -> res_valid,value=1 held stable; both readys=0; drain resumes.
//  flush while slot holds BR result and res_ready=0 -> res_valid=0 next cycle; held SLT result survives flush.
//  BR funct3=010 -> res_illegal=1 value=0; rst_n low while FULL -> res_valid=0 asynchronously.

Source files
------------

// File: rtl/comp_arbiter_pkg.sv
// Shared constants for the Execute-stage comparator and its arbiter:
// funct3 codes, decoded-op layout, result source tags and slot state type.
package comp_arbiter_pkg;

  localparam int XLEN         = 32;
  localparam int OPLEN        = 8;
  localparam int FUNCT3_BIT_M = 2;
  localparam int FUNCT3_BIT_L = 0;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic RES_SRC_BR  = 1'b0;
  localparam logic RES_SRC_SLT = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  // Only the funct3 field of the decoded op is populated; remaining bits stay 0.
  function automatic logic [OPLEN-1:0] build_op(input logic [2:0] funct3);
    logic [OPLEN-1:0] op;
    op = '0;
    op[FUNCT3_BIT_M:FUNCT3_BIT_L] = funct3;
    return op;
  endfunction

endpackage

// File: rtl/comp_arbiter_comp.sv
// Combinational branch-style comparator. Unsupported funct3 codes raise
// o_illegal and force o_result low so no undefined value leaks out.
module comp_arbiter_comp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]                     i_rs1,
  input  logic [XLEN-1:0]                     i_rs2,
  input  logic [comp_arbiter_pkg::OPLEN-1:0]  i_op,
  output logic                                o_result,
  output logic                                o_illegal
);
  import comp_arbiter_pkg::*;

  logic [2:0] w_funct3;
  logic       w_eq;
  logic       w_lt_s;
  logic       w_lt_u;

  assign w_funct3 = i_op[FUNCT3_BIT_M:FUNCT3_BIT_L];
  assign w_eq     = (i_rs1 == i_rs2);
  assign w_lt_s   = ($signed(i_rs1) < $signed(i_rs2));
  assign w_lt_u   = (i_rs1 < i_rs2);

  always_comb begin
    o_result  = 1'b0;
    o_illegal = 1'b0;
    case (w_funct3)
      FUNCT3_BEQ:  o_result = w_eq;
      FUNCT3_BNE:  o_result = !w_eq;
      FUNCT3_BLT:  o_result = w_lt_s;
      FUNCT3_BGE:  o_result = !w_lt_s;
      FUNCT3_BLTU: o_result = w_lt_u;
      FUNCT3_BGEU: o_result = !w_lt_u;
      default:     o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/comp_arbiter.sv
// Shares one comparator between the branch unit and the SLT/SLTU path.
// BR has priority with bounded SLT starvation; the 1-bit result sits in a valid/ready slot.
module comp_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [XLEN-1:0] br_rs1,
  input  logic [XLEN-1:0] br_rs2,
  input  logic [2:0]      br_funct3,
  input  logic            slt_valid,
  output logic            slt_ready,
  input  logic [XLEN-1:0] slt_rs1,
  input  logic [XLEN-1:0] slt_rs2,
  input  logic            slt_unsigned,
  input  logic            flush,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_src,
  output logic            res_value,
  output logic            res_illegal
);
  import comp_arbiter_pkg::*;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  slot_state_e r_state;
  logic [3:0]  r_starve_cnt;
  logic        r_res_src;
  logic        r_res_value;
  logic        r_res_illegal;

  logic                w_drain;
  logic                w_can_load;
  logic                w_starved;
  logic                w_br_grant;
  logic                w_slt_grant;
  logic                w_br_acc;
  logic                w_slt_acc;
  logic                w_accept;
  logic [XLEN-1:0]     w_rs1;
  logic [XLEN-1:0]     w_rs2;
  logic [2:0]          w_funct3;
  logic [OPLEN-1:0]    w_op;
  logic                w_comp_result;
  logic                w_comp_illegal;

  assign w_drain    = (r_state == ST_FULL) && res_ready;
  assign w_can_load = (r_state == ST_EMPTY) || w_drain;

  // SLT is forced only once BR has won STARVE_MAX times in a row while SLT waited.
  assign w_starved   = slt_valid && (r_starve_cnt == STARVE_LIM);
  assign w_br_grant  = br_valid && !flush && !w_starved;
  assign w_slt_grant = slt_valid && !w_br_grant;

  assign br_ready  = w_can_load && w_br_grant;
  assign slt_ready = w_can_load && w_slt_grant;
  assign w_br_acc  = br_valid && br_ready;
  assign w_slt_acc = slt_valid && slt_ready;
  assign w_accept  = w_br_acc || w_slt_acc;

  assign w_rs1    = w_br_grant ? br_rs1 : slt_rs1;
  assign w_rs2    = w_br_grant ? br_rs2 : slt_rs2;
  assign w_funct3 = w_br_grant ? br_funct3 : (slt_unsigned ? FUNCT3_BLTU : FUNCT3_BLT);
  assign w_op     = build_op(w_funct3);

  comp_arbiter_comp #(
    .XLEN (XLEN)
  ) u_comp (
    .i_rs1     (w_rs1),
    .i_rs2     (w_rs2),
    .i_op      (w_op),
    .o_result  (w_comp_result),
    .o_illegal (w_comp_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!slt_valid || w_slt_acc) begin
      r_starve_cnt <= '0;
    end else if (w_br_acc && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_EMPTY;
      r_res_src     <= RES_SRC_BR;
      r_res_value   <= 1'b0;
      r_res_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state       <= ST_FULL;
            r_res_src     <= w_br_acc ? RES_SRC_BR : RES_SRC_SLT;
            r_res_value   <= w_br_acc ? (w_comp_result && !w_comp_illegal) : w_comp_result;
            r_res_illegal <= w_br_acc && w_comp_illegal;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            r_state       <= ST_FULL;
            r_res_src     <= w_br_acc ? RES_SRC_BR : RES_SRC_SLT;
            r_res_value   <= w_br_acc ? (w_comp_result && !w_comp_illegal) : w_comp_result;
            r_res_illegal <= w_br_acc && w_comp_illegal;
          end else if (w_drain) begin
            r_state <= ST_EMPTY;
          end else if (flush && (r_res_src == RES_SRC_BR)) begin
            // A held branch result is stale after a flush; SLT results are kept.
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign res_valid   = (r_state == ST_FULL);
  assign res_src     = r_res_src;
  assign res_value   = r_res_value;
  assign res_illegal = r_res_illegal;

endmodule

// File: tb/tb_comp_arbiter.sv
// Directed bench for comp_arbiter: hand-computed vectors for grant order,
// hold/drain, flush, illegal funct3 and asynchronous reset.
module tb_comp_arbiter;

  logic        clk;
  logic        rst_n;
  logic        br_valid;
  logic        br_ready;
  logic [31:0] br_rs1;
  logic [31:0] br_rs2;
  logic [2:0]  br_funct3;
  logic        slt_valid;
  logic        slt_ready;
  logic [31:0] slt_rs1;
  logic [31:0] slt_rs2;
  logic        slt_unsigned;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic        res_src;
  logic        res_value;
  logic        res_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  comp_arbiter #(
    .XLEN       (32),
    .STARVE_MAX (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .br_valid     (br_valid),
    .br_ready     (br_ready),
    .br_rs1       (br_rs1),
    .br_rs2       (br_rs2),
    .br_funct3    (br_funct3),
    .slt_valid    (slt_valid),
    .slt_ready    (slt_ready),
    .slt_rs1      (slt_rs1),
    .slt_rs2      (slt_rs2),
    .slt_unsigned (slt_unsigned),
    .flush        (flush),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_src      (res_src),
    .res_value    (res_value),
    .res_illegal  (res_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-14s ok   got=%0h", tag, obs);
    end else begin
      $display("FAIL %-14s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_br[8] = '{1, 1, 1, 0, 1, 1, 1, 0};

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_rs1 = '0; br_rs2 = '0; br_funct3 = 3'b000;
    slt_valid = 1'b0; slt_rs1 = '0; slt_rs2 = '0; slt_unsigned = 1'b0;
    flush = 1'b0; res_ready = 1'b1;
    step();
    check("rst_valid", 32'(res_valid), 0);
    check("rst_src", 32'(res_src), 0);
    check("rst_value", 32'(res_value), 0);
    check("rst_illegal", 32'(res_illegal), 0);
    step();
    rst_n = 1'b1;

    // BLT -1 < 1 signed
    br_valid = 1'b1; br_funct3 = 3'b100; br_rs1 = 32'hFFFF_FFFF; br_rs2 = 32'd1;
    #1 check("blt_br_ready", 32'(br_ready), 1);
    step();
    br_valid = 1'b0;
    check("blt_valid", 32'(res_valid), 1);
    check("blt_src", 32'(res_src), 0);
    check("blt_value", 32'(res_value), 1);

    // SLTU 0xFFFFFFFF < 1 -> 0, then SLT same operands -> 1
    slt_valid = 1'b1; slt_unsigned = 1'b1; slt_rs1 = 32'hFFFF_FFFF; slt_rs2 = 32'd1;
    #1 check("sltu_ready", 32'(slt_ready), 1);
    step();
    check("sltu_src", 32'(res_src), 1);
    check("sltu_value", 32'(res_value), 0);
    slt_unsigned = 1'b0;
    #1 check("slt_ready", 32'(slt_ready), 1);
    step();
    slt_valid = 1'b0;
    check("slt_src", 32'(res_src), 1);
    check("slt_value", 32'(res_value), 1);

    // Both requesting every cycle: BR,BR,BR,SLT repeating
    br_valid = 1'b1; br_funct3 = 3'b000; br_rs1 = 32'd0; br_rs2 = 32'd0;
    slt_valid = 1'b1; slt_rs1 = 32'd0; slt_rs2 = 32'd0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("grant_br%0d", i), 32'(br_ready), 32'(exp_br[i]));
      check($sformatf("grant_slt%0d", i), 32'(slt_ready), 32'(1 - exp_br[i]));
      if (i > 0) check($sformatf("grant_src%0d", i), 32'(res_src), 32'(1 - exp_br[i-1]));
      step();
    end
    br_valid = 1'b0; slt_valid = 1'b0;
    check("grant_src_last", 32'(res_src), 1);
    check("grant_value", 32'(res_value), 0);
    step();
    check("drain_empty", 32'(res_valid), 0);

    // BEQ 5==5 held while res_ready=0
    br_valid = 1'b1; br_funct3 = 3'b000; br_rs1 = 32'd5; br_rs2 = 32'd5; res_ready = 1'b0;
    #1 check("beq_ready", 32'(br_ready), 1);
    step();
    br_funct3 = 3'b001; slt_valid = 1'b1; slt_rs1 = 32'd9; slt_rs2 = 32'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold_valid%0d", i), 32'(res_valid), 1);
      check($sformatf("hold_value%0d", i), 32'(res_value), 1);
      check($sformatf("hold_readys%0d", i), {30'd0, br_ready, slt_ready}, 0);
      step();
    end
    res_ready = 1'b1;
    #1 check("resume_br", 32'(br_ready), 1);
    check("resume_slt", 32'(slt_ready), 0);
    step();
    br_valid = 1'b0; slt_valid = 1'b0; res_ready = 1'b0;
    check("bne_valid", 32'(res_valid), 1);
    check("bne_value", 32'(res_value), 0);
    check("bne_src", 32'(res_src), 0);

    // Flush drops a held BR result
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_br", 32'(res_valid), 0);

    // Flush keeps a held SLT result (3 < 7 signed)
    slt_valid = 1'b1; slt_rs1 = 32'd3; slt_rs2 = 32'd7;
    #1 check("slt3_ready", 32'(slt_ready), 1);
    step();
    slt_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_slt_v", 32'(res_valid), 1);
    check("flush_slt_src", 32'(res_src), 1);
    check("flush_slt_val", 32'(res_value), 1);
    res_ready = 1'b1;
    step();
    check("flush_drain", 32'(res_valid), 0);

    // Flush blocks BR acceptance even with an empty slot
    br_valid = 1'b1; br_funct3 = 3'b000; flush = 1'b1;
    #1 check("flush_br_rdy", 32'(br_ready), 0);
    step();
    flush = 1'b0;
    check("flush_no_load", 32'(res_valid), 0);

    // Illegal funct3 010, then asynchronous reset while FULL
    br_funct3 = 3'b010; br_rs1 = 32'd1; br_rs2 = 32'd1; res_ready = 1'b0;
    #1 check("ill_ready", 32'(br_ready), 1);
    step();
    br_valid = 1'b0;
    check("ill_flag", 32'(res_illegal), 1);
    check("ill_value", 32'(res_value), 0);
    check("ill_valid", 32'(res_valid), 1);
    #2 rst_n = 1'b0;
    #1 check("async_valid", 32'(res_valid), 0);
    check("async_illegal", 32'(res_illegal), 0);
    step();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
